// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions for the sequential ALU.
package alu_pkg;
   localparam logic [3:0] CMD_AND = 4'd0;
   localparam logic [3:0] CMD_XOR = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_RSB = 4'd3;
   localparam logic [3:0] CMD_ADD = 4'd4;
   localparam logic [3:0] CMD_ADC = 4'd5;
   localparam logic [3:0] CMD_SBC = 4'd6;
   localparam logic [3:0] CMD_MUL = 4'd9;
   localparam logic [3:0] CMD_CMP = 4'd10;
   localparam logic [3:0] CMD_OR  = 4'd12;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {IDLE, MUL} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps per product.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0] mplier_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] acc_next;
   logic [CW-1:0]    count_reg;
   logic             run_reg;

   assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
   // The final step's sum is handed out combinationally so the product lands on the done edge.
   assign done     = run_reg && (count_reg == '0);
   assign product  = acc_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         count_reg  <= '0;
         run_reg    <= 1'b0;
      end else if (start) begin
         mcand_reg  <= a;
         mplier_reg <= b;
         acc_reg    <= '0;
         count_reg  <= CW'(WIDTH - 1);
         run_reg    <= 1'b1;
      end else if (run_reg) begin
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         acc_reg    <= acc_next;
         if (count_reg == '0)
            run_reg <= 1'b0;
         else
            count_reg <= count_reg - 1'b1;
      end
   end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, NZCV flags register and an iterative MUL.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       cmd,
   input  logic             set_flags,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             busy
);
   localparam int M = WIDTH - 1;

   state_t           state_reg;
   logic             out_valid_reg;
   logic [WIDTH-1:0] result_reg;
   logic [3:0]       flags_reg;
   logic             busy_reg;
   logic             mul_setf_reg;

   logic             accept;
   logic             is_mul;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   logic             legal, add_op, sub_op, op_cin;
   logic [WIDTH-1:0] op_m, op_s, logic_res, res_next;
   logic [WIDTH:0]   sum_w, diff_w;
   logic             c_next, v_next;
   logic [3:0]       flags_next;
   logic             wr_flags;

   assign in_ready  = (state_reg == IDLE) && (!out_valid_reg || out_ready);
   assign accept    = in_valid && in_ready;
   assign is_mul    = MUL_EN && (cmd == CMD_MUL);
   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign flags     = flags_reg;
   assign busy      = busy_reg;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (accept && is_mul),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      op_m      = a;
      op_s      = b;
      op_cin    = 1'b0;
      add_op    = 1'b0;
      sub_op    = 1'b0;
      legal     = 1'b1;
      logic_res = '0;
      case (cmd)
         CMD_AND: logic_res = a & b;
         CMD_XOR: logic_res = a ^ b;
         CMD_OR:  logic_res = a | b;
         CMD_ADD: add_op = 1'b1;
         CMD_ADC: begin add_op = 1'b1; op_cin = flags_reg[FLAG_C]; end
         CMD_SUB, CMD_CMP: sub_op = 1'b1;
         CMD_RSB: begin sub_op = 1'b1; op_m = b; op_s = a; end
         CMD_SBC: begin sub_op = 1'b1; op_cin = !flags_reg[FLAG_C]; end
         CMD_MUL: legal = MUL_EN;
         default: legal = 1'b0;
      endcase
   end

   // op_cin doubles as carry-in for add-class and borrow-in for subtract-class.
   assign sum_w  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(op_cin);
   assign diff_w = {1'b0, op_m} - {1'b0, op_s} - (WIDTH+1)'(op_cin);

   always_comb begin
      res_next = logic_res;
      c_next   = flags_reg[FLAG_C];
      v_next   = flags_reg[FLAG_V];
      if (add_op) begin
         res_next = sum_w[M:0];
         c_next   = sum_w[WIDTH];
         v_next   = (a[M] == b[M]) && (sum_w[M] != a[M]);
      end else if (sub_op) begin
         res_next = diff_w[M:0];
         c_next   = !diff_w[WIDTH];
         v_next   = (op_m[M] != op_s[M]) && (diff_w[M] != op_m[M]);
      end
      flags_next = {res_next[M], res_next == '0, c_next, v_next};
   end

   assign wr_flags = legal && (set_flags || cmd == CMD_CMP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         flags_reg     <= 4'b0000;
         busy_reg      <= 1'b0;
         mul_setf_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state_reg     <= MUL;
                     busy_reg      <= 1'b1;
                     out_valid_reg <= 1'b0;
                     mul_setf_reg  <= set_flags;
                  end else begin
                     result_reg    <= res_next;
                     out_valid_reg <= 1'b1;
                     if (wr_flags)
                        flags_reg <= flags_next;
                  end
               end else if (out_ready) begin
                  out_valid_reg <= 1'b0;
               end
            end
            MUL: begin
               if (mul_done) begin
                  state_reg     <= IDLE;
                  busy_reg      <= 1'b0;
                  result_reg    <= mul_product;
                  out_valid_reg <= 1'b1;
                  if (mul_setf_reg) begin
                     flags_reg[FLAG_N] <= mul_product[M];
                     flags_reg[FLAG_Z] <= (mul_product == '0);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset, in_valid, in_ready, set_flags, out_valid, out_ready, busy;
   logic [3:0]    cmd, flags;
   logic [W-1:0]  a, b, result;

   alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .cmd(cmd), .set_flags(set_flags), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .flags(flags), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] res;
      logic [3:0]   flg;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] mflags;
   int         n_vec = 0;
   int         n_err = 0;
   int         n_acc = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: integer arithmetic, range-checked signed overflow, unsigned compare for carry.
   task automatic model_accept(input logic [3:0] c, input logic sf, input logic [W-1:0] x, input logic [W-1:0] y);
      longint unsigned ux, uy, um, us, full;
      longint sx, sy, sm, ss, sv, hi, lo;
      logic [W-1:0] r;
      logic legal, f_c, f_v;
      int   cin;
      ux = x; uy = y;
      sx = longint'($signed(x)); sy = longint'($signed(y));
      hi = (longint'(1) << (W-1)) - 1;
      lo = -(longint'(1) << (W-1));
      r = '0; legal = 1'b1; f_c = mflags[1]; f_v = mflags[0];
      case (c)
         4'd0:  r = x & y;
         4'd1:  r = x ^ y;
         4'd12: r = x | y;
         4'd9:  r = W'(ux * uy);
         4'd4, 4'd5: begin
            cin  = (c == 4'd5) ? int'(mflags[1]) : 0;
            full = ux + uy + longint'(cin);
            r    = W'(full);
            f_c  = full[W];
            sv   = sx + sy + longint'(cin);
            f_v  = (sv > hi) || (sv < lo);
         end
         4'd2, 4'd3, 4'd6, 4'd10: begin
            if (c == 4'd3) begin um = uy; us = ux; sm = sy; ss = sx; end
            else begin um = ux; us = uy; sm = sx; ss = sy; end
            cin = (c == 4'd6) ? int'(!mflags[1]) : 0;
            r   = W'(um - us - longint'(cin));
            f_c = (um >= us + longint'(cin));
            sv  = sm - ss - longint'(cin);
            f_v = (sv > hi) || (sv < lo);
         end
         default: legal = 1'b0;
      endcase
      if (legal && (sf || c == 4'd10))
         mflags = {r[W-1], r == '0, f_c, f_v};
      exp_q.push_back('{res: r, flg: mflags});
      n_acc++;
   endtask

   // One clock: drive at negedge, score any consume, model any accept, return just after posedge.
   task automatic step(input logic iv, input logic [3:0] c, input logic sf,
                       input logic [W-1:0] x, input logic [W-1:0] y, input logic ordy);
      exp_t e;
      @(negedge clk);
      in_valid = iv; cmd = c; set_flags = sf; a = x; b = y; out_ready = ordy;
      #1;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            e = exp_q.pop_front();
            $display("txn result=%h flags=%b", result, flags);
            chk("result", result, e.res);
            chk("flags", flags, e.flg);
         end
      end
      if (in_valid && in_ready)
         model_accept(c, sf, x, y);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 4'd0, 1'b0, '0, '0, 1'b1);
   endtask

   task automatic mul_run(input logic [W-1:0] x, input logic [W-1:0] y, input logic sf,
                          output int lat, output int busy_cnt);
      step(1'b1, 4'd9, sf, x, y, 1'b1);
      lat = 0;
      busy_cnt = (busy && !in_ready) ? 1 : 0;
      while (!out_valid && lat < 40) begin
         idle();
         lat++;
         if (!out_valid && busy && !in_ready) busy_cnt++;
      end
   endtask

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return W'($urandom);
      endcase
   endfunction

   logic [3:0] fast_cmds [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd12};

   initial begin
      int lat, bcnt, n0, guard;
      logic [W-1:0] hold_res;
      reset = 1'b1; in_valid = 1'b0; cmd = '0; set_flags = 1'b0;
      a = '0; b = '0; out_ready = 1'b0; mflags = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk) reset = 1'b0;
      #1 chk("rst_in_ready", in_ready, 1);

      step(1'b1, 4'd4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b1);
      chk("add_ovf_valid", out_valid, 1);
      chk("add_ovf_res", result, 32'h8000_0000);
      chk("add_ovf_flags", flags, 4'b1001);
      step(1'b1, 4'd10, 1'b0, 32'd5, 32'd5, 1'b1);
      chk("cmp_res", result, 0);
      chk("cmp_flags", flags, 4'b0110);
      step(1'b1, 4'd2, 1'b0, 32'd5, 32'd5, 1'b1);
      chk("sub_noflag", flags, 4'b0110);

      step(1'b1, 4'd4, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1);
      chk("add_carry_flags", flags, 4'b0110);
      step(1'b1, 4'd5, 1'b1, 32'd2, 32'd3, 1'b1);
      chk("adc_res", result, 6);
      chk("adc_flags", flags, 4'b0000);
      step(1'b1, 4'd6, 1'b1, 32'd10, 32'd3, 1'b1);
      chk("sbc_res", result, 6);
      chk("sbc_flags", flags, 4'b0010);

      mul_run(32'h0001_0000, 32'h0001_0000, 1'b1, lat, bcnt);
      chk("mul_latency", lat, 32);
      chk("mul_busy_cycles", bcnt, 32);
      chk("mul_wrap_res", result, 0);
      chk("mul_wrap_flags", flags, 4'b0110);
      mul_run(32'd7, 32'd6, 1'b0, lat, bcnt);
      chk("mul7x6_latency", lat, 32);
      chk("mul7x6_res", result, 42);
      chk("mul7x6_flags", flags, 4'b0110);

      step(1'b1, 4'd0, 1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1);
      chk("and_res", result, 32'h0F0F_0000);
      chk("and_flags", flags, 4'b0010);
      hold_res = result;
      repeat (5) begin
         step(1'b1, 4'd4, 1'b1, W'($urandom), W'($urandom), 1'b0);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_valid", out_valid, 1);
         chk("bp_result", result, hold_res);
         chk("bp_flags", flags, 4'b0010);
      end
      n0 = n_acc;
      repeat (6) step(1'b1, fast_cmds[$urandom_range(0, 8)], 1'b1, rnd_op(), rnd_op(), 1'b1);
      chk("stream_accepts", n_acc - n0, 6);

      step(1'b1, 4'd9, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      repeat (9) idle();
      chk("mid_mul_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_flags", flags, 0);
      chk("abort_busy", busy, 0);
      chk("abort_result", result, 0);
      exp_q.delete();
      mflags = 4'b0000;
      @(negedge clk) reset = 1'b0;
      #1 chk("post_abort_ready", in_ready, 1);

      step(1'b1, 4'd4, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1);
      step(1'b1, 4'd15, 1'b1, 32'h123, 32'h456, 1'b1);
      chk("illegal_valid", out_valid, 1);
      chk("illegal_res", result, 0);
      chk("illegal_flags", flags, 4'b0110);

      repeat (400)
         step($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              rnd_op(), rnd_op(), $urandom_range(0, 9) < 7);

      guard = 0;
      while (exp_q.size() > 0 && guard < 100) begin
         idle();
         guard++;
      end
      chk("drain_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
